// File: rtl/obstacle_scroller_pkg.sv
// obstacle_scroller_pkg: shared playfield geometry and lane FSM encoding for the obstacle pipeline
package obstacle_scroller_pkg;
  localparam int unsigned X_MAX    = 849;
  localparam int unsigned BASE_W   = 40;
  localparam int unsigned W_STEP   = 8;
  localparam int unsigned GAP_BASE = 120;
  localparam int unsigned GAP_STEP = 40;
  localparam int unsigned PLAYER_X = 200;
  localparam int unsigned STAGGER  = 200;
  typedef enum logic {MOVE = 1'b0, RESPAWN = 1'b1} lane_state_e;
  function automatic logic [9:0] lane_width(input logic [2:0] s);
    return 10'(BASE_W + W_STEP * s);
  endfunction
  function automatic logic [9:0] lane_gap(input logic [2:0] s);
    return 10'(GAP_BASE + GAP_STEP * s);
  endfunction
  function automatic logic [9:0] init_h(input int k);
    return 10'(X_MAX - BASE_W - k * STAGGER);
  endfunction
endpackage

// File: rtl/obstacle_lane.sv
// obstacle_lane: one scrolling tube lane with respawn FSM and player-crossing flag
module obstacle_lane
  import obstacle_scroller_pkg::*;
#(
  parameter logic [9:0] INIT_H = 10'd809
) (
  input  logic       clk_100hz,
  input  logic       rst,
  input  logic       enable_i,
  input  logic [3:0] speed_i,
  input  logic [2:0] state_i,
  output logic [9:0] h_o,
  output logic [9:0] width_o,
  output logic [9:0] gap_y_o,
  output logic       pass_o
);
  lane_state_e st_q, st_d;
  logic [9:0] h_q, h_d, w_q, w_d, g_q, g_d, spd, h_mv;
  assign spd  = {6'd0, speed_i};
  assign h_mv = h_q - spd;
  always_comb begin
    st_d   = st_q;
    h_d    = h_q;
    w_d    = w_q;
    g_d    = g_q;
    pass_o = 1'b0;
    if (st_q == RESPAWN) begin
      w_d  = lane_width(state_i);
      g_d  = lane_gap(state_i);
      h_d  = 10'(X_MAX) - w_d;
      st_d = MOVE;
    end else if (enable_i) begin
      if (h_q >= spd) begin
        h_d    = h_mv;
        pass_o = (h_q >= 10'(PLAYER_X)) && (h_mv < 10'(PLAYER_X));
      end else begin
        st_d = RESPAWN;
      end
    end
  end
  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      st_q <= MOVE;
      h_q  <= INIT_H;
      w_q  <= 10'(BASE_W);
      g_q  <= 10'(GAP_BASE);
    end else begin
      st_q <= st_d;
      h_q  <= h_d;
      w_q  <= w_d;
      g_q  <= g_d;
    end
  end
  assign h_o     = h_q;
  assign width_o = w_q;
  assign gap_y_o = g_q;
endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: four staggered tube lanes with combined pass pulse and saturating pass count
module obstacle_scroller
  import obstacle_scroller_pkg::*;
(
  input  logic       clk_100hz,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] speed,
  input  logic [2:0] tube_state_0,
  input  logic [2:0] tube_state_1,
  input  logic [2:0] tube_state_2,
  input  logic [2:0] tube_state_3,
  output logic [9:0] tube_h_0,
  output logic [9:0] tube_h_1,
  output logic [9:0] tube_h_2,
  output logic [9:0] tube_h_3,
  output logic [9:0] tube_width_0,
  output logic [9:0] tube_width_1,
  output logic [9:0] tube_width_2,
  output logic [9:0] tube_width_3,
  output logic [9:0] tube_gap_y_0,
  output logic [9:0] tube_gap_y_1,
  output logic [9:0] tube_gap_y_2,
  output logic [9:0] tube_gap_y_3,
  output logic       pass_pulse,
  output logic [7:0] pass_count
);
  logic [2:0] st [4];
  logic [9:0] h [4];
  logic [9:0] w [4];
  logic [9:0] g [4];
  logic [3:0] pass;
  logic [2:0] n_pass;
  logic [8:0] sum;
  logic [7:0] cnt_q, cnt_d;
  logic       pulse_q;
  assign st = '{tube_state_0, tube_state_1, tube_state_2, tube_state_3};
  for (genvar k = 0; k < 4; k++) begin : g_lane
    obstacle_lane #(.INIT_H(init_h(k))) u_lane (
      .clk_100hz(clk_100hz),
      .rst      (rst),
      .enable_i (enable),
      .speed_i  (speed),
      .state_i  (st[k]),
      .h_o      (h[k]),
      .width_o  (w[k]),
      .gap_y_o  (g[k]),
      .pass_o   (pass[k])
    );
  end
  assign n_pass = 3'(pass[0]) + 3'(pass[1]) + 3'(pass[2]) + 3'(pass[3]);
  assign sum    = {1'b0, cnt_q} + {6'd0, n_pass};
  assign cnt_d  = sum[8] ? 8'hFF : sum[7:0];
  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      pulse_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      pulse_q <= |pass;
      cnt_q   <= cnt_d;
    end
  end
  assign tube_h_0     = h[0];
  assign tube_h_1     = h[1];
  assign tube_h_2     = h[2];
  assign tube_h_3     = h[3];
  assign tube_width_0 = w[0];
  assign tube_width_1 = w[1];
  assign tube_width_2 = w[2];
  assign tube_width_3 = w[3];
  assign tube_gap_y_0 = g[0];
  assign tube_gap_y_1 = g[1];
  assign tube_gap_y_2 = g[2];
  assign tube_gap_y_3 = g[3];
  assign pass_pulse   = pulse_q;
  assign pass_count   = cnt_q;
endmodule
